// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
// Boot-stage program loader for the MIPS32 core. It accepts a framed image
// on a valid/ready word stream: a header word N (data length), N data words,
// then one checksum word C. Each data word goes to the instruction memory
// write port. C must equal the mod-2**32 sum of the data words. The core is
// released from reset only after a frame has loaded and its checksum matched.
//
// Ports:
//   clk_1       single clock, rising edge
//   rst         synchronous active-high reset
//   load_start  one-cycle pulse, starts a new frame (only in IDLE/DONE/ERR)
//   s_valid     stream word valid
//   s_data      stream word
//   s_ready     loader accepts s_data this cycle (HDR/DATA/CKSUM)
//   imem_we     instruction memory write enable (one pulse per data word)
//   imem_addr   instruction memory word address (holds when imem_we=0)
//   imem_wdata  instruction memory write data (holds when imem_we=0)
//   cpu_rst     active-high hold-in-reset to the core
//   busy        a frame is in progress
//   done        last frame loaded and checksum matched
//   err         last frame rejected
//   word_cnt    data words written in the current/last frame
module mips32_prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_1,
  input  logic              rst,
  input  logic              load_start,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [32:0]       DEPTH_L = 33'(DEPTH);
  localparam logic [32:0]       BASE_L  = 33'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      acc;
  logic [CNT_W-1:0] n_len;

  logic        xfer;
  logic        hdr_zero;
  logic        hdr_bad;
  logic        last_word;
  logic [32:0] hdr_end;

  assign s_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CKSUM);
  assign busy    = s_ready;
  assign xfer    = s_valid && s_ready;

  // Header checks done at full width so a huge N cannot alias into range:
  // reject N above capacity, or any non-empty image ending past DEPTH-1.
  assign hdr_end  = {1'b0, s_data} + BASE_L;
  assign hdr_zero = (s_data == '0);
  assign hdr_bad  = ({1'b0, s_data} > DEPTH_L) || (!hdr_zero && (hdr_end > DEPTH_L));

  // word_cnt doubles as the data index: it counts accepted data words.
  assign last_word = (word_cnt == (n_len - ONE_C));

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst   = 1'b1;
    case (state)
      S_IDLE: begin
        if (load_start) state_nxt = S_HDR;
      end
      S_HDR: begin
        if (xfer) begin
          if (hdr_bad)       state_nxt = S_ERR;
          else if (hdr_zero) state_nxt = S_CKSUM;
          else               state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && last_word) state_nxt = S_CKSUM;
      end
      S_CKSUM: begin
        if (xfer) state_nxt = (s_data == acc) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (load_start) state_nxt = S_HDR;
      end
      S_ERR: begin
        err = 1'b1;
        if (load_start) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath. The write port is registered, so each accepted data word is
  // written in the cycle after its transfer; reset clears imem_we, which
  // drops a write that was accepted but not yet issued.
  always_ff @(posedge clk_1) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
      acc        <= '0;
      n_len      <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_start) begin
            word_cnt <= '0;
            acc      <= '0;
            n_len    <= '0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            // Cleared for every header so an empty frame checks against 0.
            acc   <= '0;
            n_len <= s_data[CNT_W-1:0];
          end
        end
        S_DATA: begin
          if (xfer) begin
            acc        <= acc + s_data;
            imem_we    <= 1'b1;
            imem_addr  <= BASE_A + word_cnt[ADDR_W-1:0];
            imem_wdata <= s_data;
            word_cnt   <= word_cnt + ONE_C;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
module tb_mips32_prog_loader;

  localparam int unsigned ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk_1 = 1'b0;
  logic              rst;
  logic              load_start;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_writes = 0;
  wr_t         exp_q[$];

  mips32_prog_loader #(
    .ADDR_W   (10),
    .DEPTH    (1024),
    .BASE_ADDR(0)
  ) dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .load_start(load_start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  always #5 clk_1 = ~clk_1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Write scoreboard: every imem_we pulse must match the oldest expected write.
  always @(negedge clk_1) begin
    if (imem_we === 1'b1) begin
      wr_t e;
      n_writes++;
      chk("write_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e.addr));
        chk("write_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a word with s_valid=1 until accepted (bounded); returns #1 after the transfer edge.
  task automatic send(input logic [31:0] w);
    int   guard = 0;
    logic rdy;
    s_valid = 1'b1;
    s_data  = w;
    do begin
      rdy = s_ready;
      @(posedge clk_1);
      #1;
      guard++;
    end while (!rdy && guard < 50);
    chk("handshake", 64'(rdy), 64'(1));
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk_1);
    #1;
    load_start = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_1);
      #1;
    end
  endtask

  logic [31:0] nom[3];
  logic [31:0] bp[7];
  logic [31:0] sum;
  int unsigned w0;

  initial begin
    nom[0] = 32'h2801000A; nom[1] = 32'h28020014; nom[2] = 32'h28030019;
    bp[0] = 32'h28020078; bp[1] = 32'h20220000; bp[2] = 32'h0CE77800; bp[3] = 32'h2822005D;
    bp[4] = 32'h0CE77800; bp[5] = 32'h24420001; bp[6] = 32'hFC000000;

    rst = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = '0;
    idle(2);
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_imem_we", 64'(imem_we), 64'(0));
    chk("rst_imem_addr", 64'(imem_addr), 64'(0));
    chk("rst_imem_wdata", 64'(imem_wdata), 64'(0));
    chk("rst_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_word_cnt", 64'(word_cnt), 64'(0));
    rst = 1'b0;
    idle(1);

    // Nominal load, s_valid held high
    pulse_start();
    chk("nom_busy", 64'(busy), 64'(1));
    send(32'd3);
    for (int unsigned i = 0; i < 3; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: nom[i]});
      send(nom[i]);
      chk("nom_we_pulse", 64'(imem_we), 64'(1));
      chk("nom_word_cnt", 64'(word_cnt), 64'(i + 1));
    end
    send(32'h78060037);
    s_valid = 1'b0;
    chk("nom_done", 64'(done), 64'(1));
    chk("nom_cpu_rst", 64'(cpu_rst), 64'(0));
    chk("nom_busy_end", 64'(busy), 64'(0));
    chk("nom_word_cnt_end", 64'(word_cnt), 64'(3));
    idle(1);

    // Bad checksum
    pulse_start();
    chk("bad_restart_done", 64'(done), 64'(0));
    chk("bad_restart_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("bad_restart_cnt", 64'(word_cnt), 64'(0));
    send(32'd3);
    for (int unsigned i = 0; i < 3; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: nom[i]});
      send(nom[i]);
    end
    send(32'h78060036);
    s_valid = 1'b0;
    chk("bad_err", 64'(err), 64'(1));
    chk("bad_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("bad_done", 64'(done), 64'(0));
    chk("bad_word_cnt", 64'(word_cnt), 64'(3));
    idle(1);

    // Backpressure: s_valid toggles 1-0-1
    pulse_start();
    chk("bp_err_cleared", 64'(err), 64'(0));
    w0 = n_writes;
    send(32'd7);
    s_valid = 1'b0;
    idle(1);
    sum = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: bp[i]});
      sum = sum + bp[i];
      send(bp[i]);
      s_valid = 1'b0;
      idle(1);
    end
    send(sum);
    s_valid = 1'b0;
    chk("bp_done", 64'(done), 64'(1));
    chk("bp_word_cnt", 64'(word_cnt), 64'(7));
    chk("bp_writes", 64'(n_writes - w0), 64'(7));
    idle(1);

    // Oversize header
    pulse_start();
    w0 = n_writes;
    send(32'd1025);
    s_valid = 1'b0;
    chk("over_err", 64'(err), 64'(1));
    chk("over_s_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b1; s_data = 32'h12345678;
    idle(2);
    s_valid = 1'b0;
    chk("over_s_ready_later", 64'(s_ready), 64'(0));
    chk("over_no_writes", 64'(n_writes - w0), 64'(0));

    // Zero-length frame
    pulse_start();
    send(32'd0);
    send(32'd0);
    s_valid = 1'b0;
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_word_cnt", 64'(word_cnt), 64'(0));
    chk("zero_no_writes", 64'(n_writes - w0), 64'(0));
    idle(1);
    pulse_start();
    chk("zero_restart_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("zero_restart_done", 64'(done), 64'(0));

    // Reset mid-frame (already in HDR)
    send(32'd3);
    exp_q.push_back('{addr: ADDR_W'(0), data: nom[0]});
    send(nom[0]);
    s_valid = 1'b0;
    load_start = 1'b1;
    idle(1);
    load_start = 1'b0;
    chk("mid_start_ignored_cnt", 64'(word_cnt), 64'(1));
    chk("mid_start_ignored_busy", 64'(busy), 64'(1));
    exp_q.push_back('{addr: ADDR_W'(1), data: nom[1]});
    send(nom[1]);
    s_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_we", 64'(imem_we), 64'(0));
    chk("mid_rst_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
    chk("mid_rst_word_cnt", 64'(word_cnt), 64'(0));
    pulse_start();
    send(32'd3);
    for (int unsigned i = 0; i < 3; i++) begin
      exp_q.push_back('{addr: ADDR_W'(i), data: nom[i]});
      send(nom[i]);
    end
    send(32'h78060037);
    s_valid = 1'b0;
    chk("reload_done", 64'(done), 64'(1));
    chk("reload_cpu_rst", 64'(cpu_rst), 64'(0));
    chk("reload_word_cnt", 64'(word_cnt), 64'(3));

    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
Upstream boot stage for the MIPS32 core. It receives a framed program image over a valid/ready word stream and writes it into the core's instruction memory write port. It verifies a trailing checksum, and only then releases the core from reset. This replaces back-door I_Mem preloading: the core starts fetching from BASE_ADDR only after a clean, checksummed load.

Parameters:
ADDR_W, 10, instruction memory address width in words
DEPTH, 1024, instruction memory capacity in words (must be ≤ 2**ADDR_W)
BASE_ADDR, 0, first word address written

Ports:
clk_1  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
load_start  input  1  one-cycle pulse: begin a new load frame
s_valid  input  1  stream word valid
s_data  input  32  stream word
s_ready  output  1  loader can accept s_data this cycle
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_W  instruction memory word address
imem_wdata  output  32  instruction memory write data
cpu_rst  output  1  active-high hold-in-reset to the MIPS32 core
busy  output  1  a frame is in progress
done  output  1  last frame loaded and checksum matched
err  output  1  last frame rejected
word_cnt  output  ADDR_W+1  data words written in the current/last frame

Behaviour:
- Reset (rst=1 at a clk_1 edge):
  - State goes to IDLE.
  - s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=1, busy=0, done=0, err=0, word_cnt=0.
  - Internal count, checksum accumulator and expected length are cleared.
- Frame format: header word N (data length), then N data words, then one checksum word C.
- A stream transfer occurs on any edge where s_valid && s_ready. s_ready=1 only in HDR, DATA and CKSUM.
- States:
  - IDLE: cpu_rst=1. On load_start, go to HDR and set busy=1.
  - HDR: on transfer, latch N.
    - If N > DEPTH, go to ERR.
    - If N == 0, go to CKSUM.
    - Otherwise go to DATA and clear the accumulator.
  - DATA: each transfer adds s_data into a 32-bit accumulator (mod 2**32, carry discarded). The word is written on the next cycle:
    - imem_we=1, imem_addr=BASE_ADDR+index (index 0..N-1), imem_wdata=word.
    - word_cnt increments in that same write cycle.
    - After the Nth transfer, go to CKSUM.
  - CKSUM: on transfer, compare s_data with the accumulator.
    - Equal: go to DONE. On the next cycle done=1, cpu_rst=0, busy=0.
    - Mismatch: go to ERR. On the next cycle err=1, cpu_rst=1, busy=0.
  - DONE: cpu_rst=0, core runs. load_start returns to HDR: cpu_rst=1 and done=0 on the next cycle, word_cnt cleared.
  - ERR: cpu_rst stays 1. load_start returns to HDR with err=0 and word_cnt cleared.
- load_start is ignored in HDR, DATA and CKSUM.
- imem_we is a one-cycle pulse per accepted data word, with no gaps added. Back-to-back transfers give back-to-back writes.
- imem_we is never asserted for header or checksum words.
- Stalls: s_valid=0 holds state. The accumulator and count do not change.
- When imem_we=0, imem_addr and imem_wdata hold their last values.
- Reset mid-frame returns to IDLE with cpu_rst=1. Words already written stay in memory. Any pending write (accepted last cycle) is dropped.
- Address arithmetic is ADDR_W bits. BASE_ADDR+N-1 must not exceed DEPTH-1; an N that would overflow is rejected at the header (go to ERR).

Test Plan:
- Nominal load: pulse load_start, stream 3, 2801000A, 28020014, 28030019, 78060037 with s_valid held high. Required:
  - Three consecutive imem_we pulses at addr 0/1/2 with those data words.
  - done=1 and cpu_rst=0 one cycle after the checksum transfer; word_cnt=3.
- Bad checksum: same stream with C=78060036. Required:
  - All 3 writes occur.
  - err=1 and cpu_rst=1 one cycle after C; done=0.
- Backpressure/gaps: the 7-word program 28020078, 20220000, 0CE77800, 2822005D, 0CE77800, 24420001, FC000000, with s_valid toggled 1-0-1 per cycle. Required:
  - Writes to addr 0..6 in order, one per accepted word.
  - Nothing is written during idle cycles; done=1 when the correct sum is sent.
- Oversize header: N=1025 (DEPTH=1024). Required: err=1 next cycle, no imem_we pulses, s_ready=0 afterwards.
- Zero length: N=0, C=0. Required: done=1 with no writes and word_cnt=0.
  - Then pulse load_start in DONE. Required: cpu_rst=1 and done=0 on the next cycle.
- Reset mid-frame: assert rst after the 2nd data word is accepted. Required:
  - Next cycle: IDLE, imem_we=0, cpu_rst=1, busy=0.
  - load_start is ignored until IDLE; a new frame loads cleanly from addr 0.
